// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// instruction width, PC increment and the default boot vector.
package pc_seq_pkg;

    localparam int          INSTR_W           = 32;
    localparam int          PC_INC            = 4;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_ISSUE,
        ST_HALT
    } state_e;

endpackage

// File: rtl/pc_sequencer_flopr.sv
// Resettable register with a parameterised reset value; holds the program counter.
module pc_sequencer_flopr #(
    parameter int                 P_WIDTH     = 32,
    parameter logic [P_WIDTH-1:0] P_RESET_VAL = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] d_i,
    output logic [P_WIDTH-1:0] q_o
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) q_o <= P_RESET_VAL;
        else          q_o <= d_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, runs the imem req/gnt/rvalid handshake and
// issues instructions to decode. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 P_WIDTH      = 32,
    parameter logic [P_WIDTH-1:0] P_RESET_VEC  = P_WIDTH'(RESET_VEC_DEFAULT),
    parameter int                 P_BOOT_DELAY = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [P_WIDTH-1:0] o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    output logic [P_WIDTH-1:0] o_pc,
    input  logic               i_redirect,
    input  logic [P_WIDTH-1:0] i_redirect_pc,
    input  logic               i_halt,
    output logic               o_halted,
    output logic               o_misalign
);

    localparam int CNT_W = (P_BOOT_DELAY < 2) ? 1 : $clog2(P_BOOT_DELAY + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0] pc_q, pc_d;
    logic               stale_q, stale_d;
    logic               drain_q, drain_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [P_WIDTH-1:0] ipc_q, ipc_d;

    logic [P_WIDTH-1:0] redir_tgt;
    logic               redir_bad;
    logic               stop;
    logic               redir_go;

`ifdef PC_MISALIGN_TRAP_EN
    assign redir_tgt = i_redirect_pc;
    assign redir_bad = i_redirect && (i_redirect_pc[1:0] != 2'b00);
`else
    logic unused_redir_lsbs;
    assign unused_redir_lsbs = ^i_redirect_pc[1:0];
    assign redir_tgt = {i_redirect_pc[P_WIDTH-1:2], 2'b00};
    assign redir_bad = 1'b0;
`endif

    // A trapped misaligned redirect stops fetch exactly like a halt request.
    assign stop     = i_halt | redir_bad;
    assign redir_go = i_redirect & ~stop;

    pc_sequencer_flopr #(
        .P_WIDTH     (P_WIDTH),
        .P_RESET_VAL (P_RESET_VEC)
    ) u_pc_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d_i     (pc_d),
        .q_o     (pc_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_BOOT;
            cnt_q   <= CNT_W'(P_BOOT_DELAY);
            stale_q <= 1'b0;
            drain_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= P_RESET_VEC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
            drain_q <= drain_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value first,
        // so no branch below can leave a signal unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        drain_d = drain_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        case (state_q)
            ST_BOOT: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else begin
                    if (redir_go) pc_d = redir_tgt;
                    if (cnt_q == '0) state_d = ST_REQ;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (stop) begin
                    if (i_imem_gnt) begin
                        state_d = ST_WAIT;
                        drain_d = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else begin
                    if (redir_go) pc_d = redir_tgt;
                    if (i_imem_gnt) begin
                        state_d = ST_WAIT;
                        stale_d = redir_go;
                    end
                end
            end
            ST_WAIT: begin
                // Once a halt is pending, only the outstanding response matters.
                if (drain_q) begin
                    if (i_imem_rvalid) begin
                        state_d = ST_HALT;
                        drain_d = 1'b0;
                        stale_d = 1'b0;
                    end
                end else if (stop) begin
                    if (i_imem_rvalid) begin
                        state_d = ST_HALT;
                        stale_d = 1'b0;
                    end else begin
                        drain_d = 1'b1;
                    end
                end else if (redir_go) begin
                    pc_d = redir_tgt;
                    if (i_imem_rvalid) begin
                        state_d = ST_REQ;
                        stale_d = 1'b0;
                    end else begin
                        stale_d = 1'b1;
                    end
                end else if (i_imem_rvalid) begin
                    stale_d = 1'b0;
                    if (stale_q) begin
                        state_d = ST_REQ;
                    end else begin
                        instr_d = i_imem_rdata;
                        ipc_d   = pc_q;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else if (redir_go) begin
                    pc_d    = redir_tgt;
                    state_d = ST_REQ;
                end else if (i_instr_ready) begin
                    pc_d    = pc_q + P_WIDTH'(PC_INC);
                    state_d = ST_REQ;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_d, misalign_q;

    always_comb begin
        misalign_d = redir_bad && !i_halt &&
                     ((state_q == ST_BOOT) || (state_q == ST_REQ) ||
                      (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !drain_q));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) misalign_q <= 1'b0;
        else          misalign_q <= misalign_d;
    end

    assign o_misalign = misalign_q;
`else
    assign o_misalign = 1'b0;
`endif

    assign o_imem_req    = (state_q == ST_REQ);
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = (state_q == ST_ISSUE);
    assign o_instr       = instr_q;
    assign o_pc          = ipc_q;
    assign o_halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a flag-based model.
module tb_pc_sequencer;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          BD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_pc;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_halt = 1'b0;
    logic        o_halted;
    logic        o_misalign;

    pc_sequencer #(
        .P_WIDTH      (W),
        .P_RESET_VEC  (RV),
        .P_BOOT_DELAY (BD)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_pc          (o_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_halted      (o_halted),
        .o_misalign    (o_misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fetch is described by what is in flight, not by states.
    bit          m_booting, m_inflight, m_holding, m_halted, m_discard, m_halt_after, m_misalign;
    int          m_boot_left;
    logic [31:0] m_pc, m_instr, m_opc;

    task automatic m_reset();
        m_booting    = 1'b1;
        m_boot_left  = BD;
        m_inflight   = 1'b0;
        m_holding    = 1'b0;
        m_halted     = 1'b0;
        m_discard    = 1'b0;
        m_halt_after = 1'b0;
        m_misalign   = 1'b0;
        m_pc         = RV;
        m_instr      = '0;
        m_opc        = RV;
    endtask

    task automatic m_step();
        logic [31:0] tgt;
        bit bad, stop, redir, pulse;
        m_misalign = 1'b0;
        if (m_halted) return;
`ifdef PC_MISALIGN_TRAP_EN
        tgt = i_redirect_pc;
        bad = i_redirect && (tgt % 4 != 0);
`else
        tgt = i_redirect_pc & 32'hFFFF_FFFC;
        bad = 1'b0;
`endif
        stop  = i_halt || bad;
        redir = i_redirect && !stop;
        pulse = bad && !i_halt;
        if (m_booting) begin
            if (stop) begin
                m_halted = 1'b1; m_misalign = pulse;
            end else begin
                if (redir) m_pc = tgt;
                if (m_boot_left == 0) m_booting = 1'b0;
                else m_boot_left--;
            end
        end else if (m_holding) begin
            if (stop) begin
                m_holding = 1'b0; m_halted = 1'b1; m_misalign = pulse;
            end else if (redir) begin
                m_holding = 1'b0; m_pc = tgt;
            end else if (i_instr_ready) begin
                m_holding = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else if (m_inflight) begin
            if (m_halt_after) begin
                if (i_imem_rvalid) begin
                    m_inflight = 1'b0; m_halt_after = 1'b0; m_discard = 1'b0; m_halted = 1'b1;
                end
            end else if (stop) begin
                m_misalign = pulse;
                if (i_imem_rvalid) begin
                    m_inflight = 1'b0; m_discard = 1'b0; m_halted = 1'b1;
                end else m_halt_after = 1'b1;
            end else if (redir) begin
                m_pc = tgt;
                if (i_imem_rvalid) begin
                    m_inflight = 1'b0; m_discard = 1'b0;
                end else m_discard = 1'b1;
            end else if (i_imem_rvalid) begin
                m_inflight = 1'b0;
                if (m_discard) m_discard = 1'b0;
                else begin
                    m_holding = 1'b1; m_instr = i_imem_rdata; m_opc = m_pc;
                end
            end
        end else begin
            if (stop) begin
                m_misalign = pulse;
                if (i_imem_gnt) begin
                    m_inflight = 1'b1; m_halt_after = 1'b1;
                end else m_halted = 1'b1;
            end else begin
                if (redir) m_pc = tgt;
                if (i_imem_gnt) begin
                    m_inflight = 1'b1; m_discard = redir;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req",    o_imem_req,
                  !m_halted && !m_booting && !m_inflight && !m_holding);
            check("imem_addr",   o_imem_addr, m_pc);
            check("instr_valid", o_instr_valid, m_holding);
            check("instr",       o_instr, m_instr);
            check("pc",          o_pc, m_opc);
            check("halted",      o_halted, m_halted);
            check("misalign",    o_misalign, m_misalign);
        end
    end

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy,
                         input logic rdr, input logic [31:0] rpc, input logic hlt);
        i_imem_gnt    = gnt;
        i_imem_rvalid = rv;
        i_imem_rdata  = rd;
        i_instr_ready = rdy;
        i_redirect    = rdr;
        i_redirect_pc = rpc;
        i_halt        = hlt;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_instr_ready = 1'b0;
        i_redirect    = 1'b0;
        i_halt        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int halted_cycles;
        do_reset();
        chk_en = 1'b1;
        check("rst_req", o_imem_req, 1'b0);
        check("rst_addr", o_imem_addr, RV);
        check("rst_valid", o_instr_valid, 1'b0);

        // Streaming fetch with immediate gnt/rvalid and ready.
        drive(1, 1, 32'h1234_5678, 1, 0, '0, 0);
        check("boot_c0_req", o_imem_req, 1'b0);
        drive(1, 1, 32'h1234_5678, 1, 0, '0, 0);
        check("boot_c1_req", o_imem_req, 1'b0);
        drive(1, 1, 32'h1234_5678, 1, 0, '0, 0);
        check("first_req", o_imem_req, 1'b1);
        check("first_addr", o_imem_addr, 32'h0);
        repeat (2) drive(1, 1, 32'h1234_5678, 1, 0, '0, 0);
        check("first_valid", o_instr_valid, 1'b1);
        check("first_instr", o_instr, 32'h1234_5678);
        check("first_pc", o_pc, 32'h0);
        drive(1, 1, 32'h1234_5678, 1, 0, '0, 0);
        check("second_addr", o_imem_addr, 32'h4);
        repeat (3) drive(1, 1, 32'h1234_5678, 1, 0, '0, 0);
        check("third_req", o_imem_req, 1'b1);
        check("third_addr", o_imem_addr, 32'h8);

        // Delayed grant holds the request and address.
        do_reset();
        repeat (3) idle();
        for (int i = 0; i < 3; i++) begin
            idle();
            check("held_req", o_imem_req, 1'b1);
            check("held_addr", o_imem_addr, 32'h0);
        end
        drive(1, 0, '0, 0, 0, '0, 0);
        check("granted_req", o_imem_req, 1'b0);

        // Redirect while waiting: response discarded, refetch from target.
        drive(0, 0, '0, 0, 1, 32'h100, 0);
        check("stale_wait_req", o_imem_req, 1'b0);
        drive(0, 1, 32'hDEAD_BEEF, 1, 0, '0, 0);
        check("stale_valid", o_instr_valid, 1'b0);
        check("redir_addr", o_imem_addr, 32'h100);

        // PC wraps past the top of the address space.
        drive(0, 0, '0, 0, 1, 32'hFFFF_FFFC, 0);
        check("top_addr", o_imem_addr, 32'hFFFF_FFFC);
        drive(1, 0, '0, 0, 0, '0, 0);
        drive(0, 1, 32'hCAFE_0001, 0, 0, '0, 0);
        check("top_pc", o_pc, 32'hFFFF_FFFC);
        drive(0, 0, '0, 1, 0, '0, 0);
        check("wrap_addr", o_imem_addr, 32'h0);

        // Misaligned redirect.
        drive(0, 0, '0, 0, 1, 32'h102, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pulse", o_misalign, 1'b1);
        check("mis_halted", o_halted, 1'b1);
        check("mis_req", o_imem_req, 1'b0);
        idle();
        check("mis_pulse_end", o_misalign, 1'b0);
`else
        check("mis_addr", o_imem_addr, 32'h100);
        check("mis_none", o_misalign, 1'b0);
        drive(0, 0, '0, 0, 0, '0, 1);
        check("halt_halted", o_halted, 1'b1);
        drive(1, 1, '0, 1, 1, 32'h200, 0);
        check("halt_sticky", o_halted, 1'b1);
        check("halt_no_req", o_imem_req, 1'b0);
`endif

        // Reset while a fetch is outstanding; late response ignored.
        do_reset();
        repeat (3) idle();
        drive(1, 0, '0, 0, 0, '0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", o_imem_req, 1'b0);
        check("mid_rst_addr", o_imem_addr, RV);
        check("mid_rst_valid", o_instr_valid, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, 1, 32'hBAD0_BAD0, 1, 0, '0, 0);
        check("late_rv_valid", o_instr_valid, 1'b0);
        check("late_rv_instr", o_instr, 32'h0);
        repeat (2) idle();
        check("post_rst_req", o_imem_req, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        halted_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(7) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF8 | (rpc & 32'h7);
            drive($urandom_range(2) != 0, $urandom_range(1) == 1, $urandom,
                  $urandom_range(3) != 0, $urandom_range(15) == 0, rpc,
                  $urandom_range(299) == 0);
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            if (halted_cycles > 4 || $urandom_range(499) == 0) begin
                do_reset();
                halted_cycles = 0;
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
